// File: rtl/phase_tag_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : phase_tag_deserializer
// Brief   : Oversampling receiver for the phase-tag serial link; rebuilds
//           MSB-first words, splits channel/header/tag and queues tags into a
//           small valid/ready FIFO. Optional header filter: PHASE_RX_HEADER_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module phase_tag_deserializer #(
  parameter int TAG_WIDTH   = 28,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 serial_clk,
  input  logic                 serial_data,
  input  logic                 serial_valid,
  output logic                 tag_valid,
  input  logic                 tag_ready,
  output logic                 tag_channel,
  output logic [TAG_WIDTH-1:0] tag_value,
  output logic [15:0]          frame_err_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int         c_word_w  = TAG_WIDTH + 4;
  localparam int         c_ptr_w   = $clog2(FIFO_DEPTH);
  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_shift   = 2'd1;
  localparam logic [1:0] c_done    = 2'd2;
  localparam logic [5:0] c_cnt_sat = 6'd33;
  localparam logic [5:0] c_cnt_ok  = 6'(c_word_w);

  logic [SYNC_STAGES-1:0] r_sync_clk;
  logic [SYNC_STAGES-1:0] r_sync_data;
  logic [SYNC_STAGES-1:0] r_sync_valid;
  logic                   r_clk_d;
  logic                   r_valid_d;
  logic                   r_bit;
  logic                   r_clk_fall;
  logic                   r_valid_rise;
  logic                   r_valid_fall;

  // Edge pulses are registered so that bit and frame-end events line up with
  // the delayed data sample r_bit.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_sync_clk   <= '0;
      r_sync_data  <= '0;
      r_sync_valid <= '0;
      r_clk_d      <= 1'b0;
      r_valid_d    <= 1'b0;
      r_bit        <= 1'b0;
      r_clk_fall   <= 1'b0;
      r_valid_rise <= 1'b0;
      r_valid_fall <= 1'b0;
    end else begin
      r_sync_clk   <= {r_sync_clk[SYNC_STAGES-2:0], serial_clk};
      r_sync_data  <= {r_sync_data[SYNC_STAGES-2:0], serial_data};
      r_sync_valid <= {r_sync_valid[SYNC_STAGES-2:0], serial_valid};
      r_clk_d      <= r_sync_clk[SYNC_STAGES-1];
      r_valid_d    <= r_sync_valid[SYNC_STAGES-1];
      r_bit        <= r_sync_data[SYNC_STAGES-1];
      r_clk_fall   <= r_clk_d & ~r_sync_clk[SYNC_STAGES-1];
      r_valid_rise <= ~r_valid_d & r_sync_valid[SYNC_STAGES-1];
      r_valid_fall <= r_valid_d & ~r_sync_valid[SYNC_STAGES-1];
    end
  end

  logic [1:0]          r_state;
  logic [5:0]          r_bit_cnt;
  logic [c_word_w-1:0] r_sh;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_bit_cnt <= '0;
      r_sh      <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (r_valid_rise) begin
            r_state   <= c_shift;
            r_bit_cnt <= '0;
          end
        end
        c_shift: begin
          // A bit arriving together with the frame end is still taken.
          if (r_clk_fall) begin
            r_sh <= {r_sh[c_word_w-2:0], r_bit};
            if (r_bit_cnt != c_cnt_sat) r_bit_cnt <= r_bit_cnt + 6'd1;
          end
          if (r_valid_fall) r_state <= c_done;
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  logic w_len_ok;
  logic w_hdr_ok;
  logic w_in_done;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_write;
  logic w_drop;
  logic w_frame_err;

  assign w_len_ok  = (r_bit_cnt == c_cnt_ok);
  assign w_in_done = (r_state == c_done);

`ifdef PHASE_RX_HEADER_CHECK_EN
  assign w_hdr_ok = (r_sh[c_word_w-2:TAG_WIDTH] == '0);
`else
  logic w_unused_hdr;
  assign w_unused_hdr = ^r_sh[c_word_w-2:TAG_WIDTH];
  assign w_hdr_ok     = 1'b1;
`endif

  logic [TAG_WIDTH:0]  r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w:0]    r_count;
  logic [15:0]         r_frame_err_cnt;
  logic [15:0]         r_drop_cnt;

  assign w_full      = (r_count == (c_ptr_w+1)'(FIFO_DEPTH));
  assign tag_valid   = (r_count != '0);
  assign w_pop       = tag_valid & tag_ready;
  assign w_push      = w_in_done & w_len_ok & w_hdr_ok;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_write     = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_frame_err = w_in_done & ~(w_len_ok & w_hdr_ok);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_frame_err_cnt <= '0;
      r_drop_cnt      <= '0;
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr] <= {r_sh[c_word_w-1], r_sh[TAG_WIDTH-1:0]};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_frame_err && (r_frame_err_cnt != 16'hFFFF))
        r_frame_err_cnt <= r_frame_err_cnt + 16'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign tag_channel   = r_mem[r_rd_ptr][TAG_WIDTH];
  assign tag_value     = r_mem[r_rd_ptr][TAG_WIDTH-1:0];
  assign frame_err_cnt = r_frame_err_cnt;
  assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phase_tag_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_phase_tag_deserializer
// Brief   : Self-checking bench for phase_tag_deserializer against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_phase_tag_deserializer;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        serial_clk;
  logic        serial_data;
  logic        serial_valid;
  logic        tag_valid;
  logic        tag_ready;
  logic        tag_channel;
  logic [27:0] tag_value;
  logic [15:0] frame_err_cnt;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [28:0] exp_q[$];
  logic [28:0] obs_q[$];
  int occ      = 0;
  int exp_err  = 0;
  int exp_drop = 0;

  phase_tag_deserializer #(.TAG_WIDTH(28), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .serial_clk   (serial_clk),
    .serial_data  (serial_data),
    .serial_valid (serial_valid),
    .tag_valid    (tag_valid),
    .tag_ready    (tag_ready),
    .tag_channel  (tag_channel),
    .tag_value    (tag_value),
    .frame_err_cnt(frame_err_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Handshakes are recorded half a cycle before the accepting edge.
  always @(negedge sys_clk)
    if (rst_n && tag_valid && tag_ready) obs_q.push_back({tag_channel, tag_value});

  function automatic void model_frame(input logic [31:0] w, input int n);
    bit bad;
    bad = (n != 32);
`ifdef PHASE_RX_HEADER_CHECK_EN
    if (w[30:28] != 3'b000) bad = 1'b1;
`endif
    if (bad) begin
      if (exp_err < 65535) exp_err++;
    end else if (occ < DEPTH) begin
      exp_q.push_back({w[31], w[27:0]});
      occ++;
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endfunction

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      serial_clk  = 1'b1;
      serial_data = (i < 32) ? w[31-i] : 1'b0;
      #40;
      serial_clk  = 1'b0;
      #40;
    end
  endtask

  // Returns 1 ns after the sys_clk edge at which serial_valid is dropped.
  task automatic send_frame(input logic [31:0] w, input int n);
    #100;
    serial_valid = 1'b1;
    #40;
    send_bits(w, n);
    #40;
    @(posedge sys_clk);
    #1 serial_valid = 1'b0;
    model_frame(w, n);
  endtask

  task automatic drain(input string name);
    repeat (10) @(posedge sys_clk);
    #1 tag_ready = 1'b1;
    repeat (12) @(posedge sys_clk);
    #1 tag_ready = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s beat_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s beat%0d: got %h expected %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (tag_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s empty_after_drain: tag_valid got %b expected 0", name, tag_valid);
    end
    obs_q.delete();
    exp_q.delete();
    occ = 0;
  endtask

  task automatic check_counters(input string name);
    checks++;
    if (frame_err_cnt !== 16'(exp_err)) begin
      failures++;
      $display("FAIL %s frame_err_cnt: got %0d expected %0d", name, frame_err_cnt, exp_err);
    end
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      failures++;
      $display("FAIL %s drop_cnt: got %0d expected %0d", name, drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; serial_clk = 1'b0; serial_data = 1'b0; serial_valid = 1'b0; tag_ready = 1'b0;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (tag_valid !== 1'b0) begin failures++; $display("FAIL reset tag_valid: got %b expected 0", tag_valid); end
    checks++;
    if (tag_channel !== 1'b0) begin failures++; $display("FAIL reset tag_channel: got %b expected 0", tag_channel); end
    checks++;
    if (tag_value !== 28'h0) begin failures++; $display("FAIL reset tag_value: got %h expected 0", tag_value); end
    check_counters("reset");
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    tag_ready = 1'b1;
    send_frame(32'h80ABCDEF, 32);
    repeat (12) @(posedge sys_clk);
    #1 tag_ready = 1'b0;
    drain("basic");
    check_counters("basic");
  endtask

  task automatic test_latency();
    int n;
    send_frame($urandom, 32);
    n = 0;
    while (tag_valid !== 1'b1 && n < 30) begin
      @(posedge sys_clk);
      #1 n++;
    end
    checks++;
    if (n != SYNC + 3) begin
      failures++;
      $display("FAIL latency: got %0d cycles expected %0d", n, SYNC + 3);
    end
    drain("latency");
  endtask

  task automatic test_malformed();
    send_frame(32'h12345678, 31);
    send_frame(32'h9ABCDEF0, 33);
    repeat (12) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (tag_valid !== 1'b0) begin failures++; $display("FAIL malformed tag_valid: got %b expected 0", tag_valid); end
    check_counters("malformed");
    drain("malformed");
  endtask

  task automatic test_fill_drop();
    logic [27:0] held;
    for (int i = 1; i <= 5; i++) send_frame(32'(i), 32);
    repeat (12) @(posedge sys_clk);
    @(negedge sys_clk);
    check_counters("fill_drop");
    held = tag_value;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      checks++;
      if (tag_valid !== 1'b1 || tag_value !== held) begin
        failures++;
        $display("FAIL hold_stable: got valid=%b value=%h expected valid=1 value=%h", tag_valid, tag_value, held);
      end
    end
    drain("fill_drop");
  endtask

  task automatic test_reset_midframe();
    repeat (5) @(posedge sys_clk);
    #100;
    serial_valid = 1'b1;
    #40;
    send_bits(32'hFFFF_FFFF, 16);
    @(posedge sys_clk);
    #1 rst_n = 1'b0;
    serial_valid = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); occ = 0; exp_err = 0; exp_drop = 0;
    @(negedge sys_clk);
    check_counters("after_reset");
    send_frame(32'h00000123, 32);
    drain("reset_midframe");
    check_counters("reset_midframe");
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 4; i++) send_frame($urandom, 32);
    repeat (12) @(posedge sys_clk);
    // The concurrent pop frees one slot for the fifth word.
    occ--;
    send_frame(32'h8765_4321, 32);
    repeat (SYNC + 2) @(posedge sys_clk);
    #1 tag_ready = 1'b1;
    @(posedge sys_clk);
    #1 tag_ready = 1'b0;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check_counters("passthrough");
    drain("passthrough");
  endtask

  task automatic test_header();
    send_frame(32'h70000005, 32);
    drain("header");
    check_counters("header");
  endtask

  task automatic test_random();
    logic [31:0] w;
    int n;
    int k;
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        w = $urandom;
        if ($urandom_range(0, 1) == 0) w[30:28] = 3'b000;
        case ($urandom_range(0, 4))
          0:       n = 31;
          1:       n = 33;
          default: n = 32;
        endcase
        send_frame(w, n);
      end
      drain("random");
      check_counters("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_malformed();
    test_fill_drop();
    test_reset_midframe();
    test_passthrough();
    test_header();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
